// File: rtl/anfsqrt_pdm_341449297858921043_pkg.sv
// Shared definitions for the sqrt-driven PDM modulator.
// Holds the default sample width and FIFO depth, the FSM state type,
// and a small saturating-increment helper for the optional underrun
// counter (enabled with ANFSQRT_PDM_UNDERRUN_CNT_EN).
package anfsqrt_pdm_pkg_341449297858921043;

  // Sample width, equal to the upstream sqrt result width.
  localparam int PDM_WIDTH = 7;

  // Sample FIFO entries; must be a power of two, at least 2.
  localparam int PDM_DEPTH = 2;

  // Modulator FSM: IDLE until the first sample arrives, then RUN forever.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Increment an 8-bit event counter, holding at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/anfsqrt_pdm_341449297858921043_fifo.sv
// Sample FIFO feeding the PDM modulator.
// Wrap-around read/write pointers carry one extra bit so that a full
// FIFO (same index, different lap) is distinguishable from an empty one
// (identical pointers). full/empty are decoded from registers only.
module anfsqrt_pdm_fifo_341449297858921043
  import anfsqrt_pdm_pkg_341449297858921043::*;
#(
  parameter int WIDTH = PDM_WIDTH,
  parameter int DEPTH = PDM_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Same index on a different lap means every entry is occupied.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Requests against a full/empty FIFO are ignored rather than corrupting it.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer advance; push and pop in one cycle both move, occupancy unchanged.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; equal pointers already mark every entry invalid.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/anfsqrt_pdm_341449297858921043.sv
// Pulse-density modulator driven by density levels from a sqrt stage.
// Each 2^WIDTH-cycle frame emits exactly `level` ones using a first-order
// accumulator whose carry is the output bit. A new level is taken from
// the sample FIFO at every frame boundary; an empty FIFO at that point
// repeats the previous level (an underrun).
// Optional feature: define ANFSQRT_PDM_UNDERRUN_CNT_EN to add the
// saturating 8-bit underrun_cnt output.
module anfsqrt_pdm_341449297858921043
  import anfsqrt_pdm_pkg_341449297858921043::*;
#(
  parameter int WIDTH = PDM_WIDTH,
  parameter int DEPTH = PDM_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pdm_out,
  output logic             pdm_out_n
`ifdef ANFSQRT_PDM_UNDERRUN_CNT_EN
  ,
  output logic [7:0]       underrun_cnt
`endif
);

  localparam logic [WIDTH-1:0] FRAME_LAST = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic             pdm_q, pdm_d;
  logic [WIDTH:0]   sum;
  logic             frame_end;

  logic             fifo_push;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  // Ready comes straight from FIFO pointer registers, never from inputs.
  assign sample_ready = !fifo_full;
  assign fifo_push    = sample_valid && sample_ready;
  assign frame_end    = (frame_q == FRAME_LAST);

  anfsqrt_pdm_fifo_341449297858921043 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (sample),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM, accumulator and frame counter next-state.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    acc_d    = acc_q;
    frame_d  = frame_q;
    pdm_d    = pdm_q;
    fifo_pop = 1'b0;
    // The carry out of acc + level is the output bit; acc keeps the remainder.
    sum      = {1'b0, acc_q} + {1'b0, level_q};
    case (state_q)
      IDLE: begin
        pdm_d   = 1'b0;
        acc_d   = '0;
        frame_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          level_d  = fifo_dout;
          state_d  = RUN;
        end
      end
      RUN: begin
        pdm_d   = sum[WIDTH];
        // acc is deliberately not cleared at frame boundaries; the remainder
        // carries over so every full frame emits exactly `level` ones.
        acc_d   = sum[WIDTH-1:0];
        frame_d = frame_q + WIDTH'(1);
        if (frame_end && !fifo_empty) begin
          fifo_pop = 1'b1;
          level_d  = fifo_dout;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Modulator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      acc_q   <= '0;
      frame_q <= '0;
      pdm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      acc_q   <= acc_d;
      frame_q <= frame_d;
      pdm_q   <= pdm_d;
    end
  end

  assign pdm_out   = pdm_q;
  assign pdm_out_n = ~pdm_q;

`ifdef ANFSQRT_PDM_UNDERRUN_CNT_EN
  logic       underrun;
  logic [7:0] underrun_q;

  // A frame boundary with nothing queued repeats the old level.
  assign underrun = (state_q == RUN) && frame_end && fifo_empty;

  // Saturating underrun event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= '0;
    end else if (underrun) begin
      underrun_q <= sat_inc8(underrun_q);
    end
  end

  assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_anfsqrt_pdm_341449297858921043.sv
// Scoreboard bench for the PDM modulator. A reference model, stepped on
// each rising edge from the bench's own stimulus, pushes the expected
// outputs into a queue; a monitor on the falling edge pops and compares.
// The model derives each output bit as the change in floor(total/2^WIDTH)
// of the running sum of levels, and counts ones per frame.
module tb_anfsqrt_pdm_341449297858921043;

  localparam int WIDTH = 7;
  localparam int DEPTH = 2;
  localparam int FRAME = 1 << WIDTH;

  typedef struct {
    bit pdm;
    bit rdy;
    int und;
    bit in_run;
    bit last;
    int lvl;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             sample_ready;
  logic             pdm_out;
  logic             pdm_out_n;
`ifdef ANFSQRT_PDM_UNDERRUN_CNT_EN
  logic [7:0]       underrun_cnt;
`endif

  int     n_tests = 0;
  int     n_fail  = 0;
  exp_t   exp_q[$];
  int     frame_log[$];
  int     ones = 0;

  // Reference model state.
  int     m_q[$];
  bit     m_run;
  int     m_level;
  int     m_fc;
  int     m_under;
  longint m_total;

  anfsqrt_pdm_341449297858921043 #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pdm_out      (pdm_out),
    .pdm_out_n    (pdm_out_n)
`ifdef ANFSQRT_PDM_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_run   = 1'b0;
    m_level = 0;
    m_fc    = 0;
    m_under = 0;
    m_total = 0;
  endtask

  // One clock of the reference model, using the inputs presented this cycle.
  task automatic model_step();
    bit   push_ok;
    exp_t e;
    push_ok  = sample_valid && (m_q.size() < DEPTH);
    e.in_run = m_run;
    e.last   = 1'b0;
    e.lvl    = m_level;
    if (!m_run) begin
      e.pdm = 1'b0;
      if (m_q.size() != 0) begin
        m_level = m_q.pop_front();
        m_run   = 1'b1;
        m_fc    = 0;
        m_total = 0;
      end
    end else begin
      e.pdm   = ((m_total + m_level) / FRAME) != (m_total / FRAME);
      m_total = m_total + m_level;
      e.last  = (m_fc == FRAME - 1);
      if (e.last) begin
        if (m_q.size() != 0) m_level = m_q.pop_front();
        else if (m_under < 255) m_under++;
      end
      m_fc = (m_fc + 1) % FRAME;
    end
    if (push_ok) m_q.push_back(int'(sample));
    e.rdy = (m_q.size() < DEPTH);
    e.und = m_under;
    exp_q.push_back(e);
  endtask

  // Model process.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Monitor: compares DUT outputs against the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pdm_out", pdm_out, e.pdm);
        check("pdm_out_n", pdm_out_n, !e.pdm);
        check("sample_ready", sample_ready, e.rdy);
`ifdef ANFSQRT_PDM_UNDERRUN_CNT_EN
        check("underrun_cnt", underrun_cnt, e.und);
`endif
        if (e.in_run) begin
          ones += int'(pdm_out);
          if (e.last) begin
            check("frame_ones", ones, e.lvl);
            frame_log.push_back(ones);
            ones = 0;
          end
        end
      end
    end
  end

  // Asynchronous reset assertion away from the clock edge, synchronous release.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    check("rst_pdm_out", pdm_out, 0);
    check("rst_pdm_out_n", pdm_out_n, 1);
    check("rst_sample_ready", sample_ready, 1);
`ifdef ANFSQRT_PDM_UNDERRUN_CNT_EN
    check("rst_underrun_cnt", underrun_cnt, 0);
`endif
    exp_q.delete();
    frame_log.delete();
    ones = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input int v);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!sample_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("push_ready", sample_ready, 1);
    sample       = WIDTH'(v);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int waited;
    waited = 0;
    while (frame_log.size() < n && waited < 4 * FRAME * (n + 1)) begin
      @(negedge clk);
      waited++;
    end
    check("frames_seen", frame_log.size() >= n, 1);
  endtask

  initial begin
    int rise;
    int cnt;
    rst_n        = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;
    #3;

    // Level 0: constant 0 for two frames.
    do_reset();
    push(0);
    wait_frames(2);
    if (frame_log.size() >= 2) begin
      check("lvl0_frame1", frame_log[0], 0);
      check("lvl0_frame2", frame_log[1], 0);
    end

    // Level 64: alternating bits, 64 ones per frame.
    do_reset();
    push(64);
    wait_frames(2);
    if (frame_log.size() >= 2) begin
      check("lvl64_frame1", frame_log[0], 64);
      check("lvl64_frame2", frame_log[1], 64);
    end

    // 127 then 5 back-to-back, then an underrun repeats 5.
    do_reset();
    push(127);
    push(5);
    wait_frames(2);
    repeat (10) @(negedge clk);
`ifdef ANFSQRT_PDM_UNDERRUN_CNT_EN
    check("underrun_after_frame2", underrun_cnt, 1);
`endif
    wait_frames(3);
    if (frame_log.size() >= 3) begin
      check("seq_frame1", frame_log[0], 127);
      check("seq_frame2", frame_log[1], 5);
      check("seq_frame3", frame_log[2], 5);
    end

    // Valid held high: FIFO fills, ready returns after the boundary pop.
    do_reset();
    @(negedge clk);
    sample_valid = 1'b1;
    sample       = WIDTH'($urandom_range(0, FRAME - 1));
    rise = -1;
    for (int i = 1; i <= 3 * FRAME; i++) begin
      @(negedge clk);
      if (i == 5) check("held_valid_full", sample_ready, 0);
      if (rise < 0 && i > 3 && sample_ready) rise = i;
      sample = WIDTH'($urandom_range(0, FRAME - 1));
    end
    sample_valid = 1'b0;
    check("held_valid_ready_rise", rise, FRAME + 2);

    // Randomized traffic including extreme levels.
    do_reset();
    for (int i = 0; i < 8 * FRAME; i++) begin
      @(negedge clk);
      sample_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) sample = $urandom_range(0, 1) ? WIDTH'(FRAME - 1) : '0;
      else sample = WIDTH'($urandom_range(0, FRAME - 1));
    end
    sample_valid = 1'b0;

    // Reset mid-frame at frame_cnt 40 with two samples queued.
    do_reset();
    push(127);
    push(127);
    push(127);
    cnt = 0;
    while (!(m_run && m_fc == 40) && cnt < 4 * FRAME) begin
      @(negedge clk);
      cnt++;
    end
    check("midrst_pre_ready", sample_ready, 0);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      cnt += int'(pdm_out);
    end
    check("midrst_ones_after", cnt, 0);
    check("midrst_ready_after", sample_ready, 1);

`ifdef ANFSQRT_PDM_UNDERRUN_CNT_EN
    // Underrun counter saturation.
    do_reset();
    push(3);
    repeat (300 * FRAME + 2 * FRAME) @(negedge clk);
    check("underrun_saturated", underrun_cnt, 255);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
